// File: rtl/wb_uart_tx_sched.sv
// Wishbone master that funnels bytes from NUM_REQ requester FIFOs into one UART TX register,
// round-robin, one write per byte, with divider (re)programming and a stall watchdog.
module wb_uart_tx_sched #(
   parameter int          NUM_REQ         = 2,
   parameter int          FIFO_DEPTH_LOG2 = 2,
   parameter int          WB_DATA_WIDTH   = 32,
   parameter int          WB_ADDR_WIDTH   = 32,
   parameter logic [31:0] UART_BASE       = 32'h0,
   parameter logic [31:0] DIVIDER_INIT    = 32'd1,
   parameter int          TIMEOUT_W       = 20
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [8*NUM_REQ-1:0]       req_data_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic                       cfg_div_valid_i,
   input  logic [31:0]                cfg_div_i,
   output logic [WB_ADDR_WIDTH-1:0]   wbm_addr_o,
   output logic [WB_DATA_WIDTH-1:0]   wbm_data_o,
   output logic [WB_DATA_WIDTH/8-1:0] wbm_sel_o,
   output logic                       wbm_we_o,
   output logic                       wbm_cyc_o,
   output logic                       wbm_stb_o,
   input  logic                       wbm_ack_i,
   input  logic [WB_DATA_WIDTH-1:0]   wbm_data_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic                       busy_o,
   output logic                       timeout_o
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SEL_W = WB_DATA_WIDTH / 8;
   localparam logic [TIMEOUT_W-1:0] WD_ABORT_AT = ~TIMEOUT_W'(1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_XFER, ST_GAP} state_t;

   state_t                     state_reg, state_next;
   logic                       cyc_reg, we_reg;
   logic [WB_ADDR_WIDTH-1:0]   addr_reg;
   logic [WB_DATA_WIDTH-1:0]   data_reg;
   logic [SEL_W-1:0]           sel_reg;
   logic [NUM_REQ-1:0]         grant_reg;
   logic [IDX_W-1:0]           last_grant_reg;
   logic                       timeout_reg;
   logic                       cfg_pending_reg;
   logic [31:0]                cfg_value_reg;
   logic [TIMEOUT_W-1:0]       wd_reg;

   logic [NUM_REQ-1:0]         fifo_nonempty;
   logic [NUM_REQ-1:0][7:0]    head_byte;
   logic                       arb_found;
   logic [IDX_W-1:0]           arb_idx, arb_cand;
   logic [NUM_REQ-1:0]         arb_onehot;
   logic                       start_cfg, start_byte, xfer_end, wd_abort;
   logic                       unused_rdata;

   assign unused_rdata = ^wbm_data_i;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
         logic [7:0]                 mem [DEPTH];
         logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
         logic [CNT_W-1:0]           count_reg;
         logic                       push, pop;

         assign req_ready_o[gi]   = (count_reg != CNT_W'(DEPTH)) && !rst_i;
         assign push              = req_valid_i[gi] && req_ready_o[gi];
         assign pop               = start_byte && (arb_idx == IDX_W'(gi));
         assign fifo_nonempty[gi] = (count_reg != '0);
         assign head_byte[gi]     = mem[rd_ptr_reg];

         always_ff @(posedge clk_i) begin
            if (push) mem[wr_ptr_reg] <= req_data_i[8*gi +: 8];
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
               if (push && !pop)      count_reg <= count_reg + 1'b1;
               else if (pop && !push) count_reg <= count_reg - 1'b1;
            end
         end
      end
   endgenerate

   // Round-robin: first non-empty FIFO after the last one served.
   always_comb begin
      arb_found  = 1'b0;
      arb_idx    = last_grant_reg;
      arb_cand   = '0;
      arb_onehot = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         arb_cand = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
         if (!arb_found && fifo_nonempty[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) arb_onehot[i] = (arb_idx == IDX_W'(i));
   end

   always_comb begin
      state_next = state_reg;
      start_cfg  = 1'b0;
      start_byte = 1'b0;
      xfer_end   = 1'b0;
      wd_abort   = 1'b0;
      case (state_reg)
         ST_INIT, ST_IDLE: begin
            if (cfg_pending_reg) begin
               start_cfg  = 1'b1;
               state_next = ST_XFER;
            end else if (arb_found) begin
               start_byte = 1'b1;
               state_next = ST_XFER;
            end
         end
         ST_XFER: begin
            if (wbm_ack_i) begin
               xfer_end   = 1'b1;
               state_next = ST_GAP;
            end else if (wd_reg == WD_ABORT_AT) begin
               xfer_end   = 1'b1;
               wd_abort   = 1'b1;
               state_next = ST_GAP;
            end
         end
         ST_GAP:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_reg <= ST_INIT;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_reg         <= 1'b0;
         we_reg          <= 1'b0;
         addr_reg        <= '0;
         data_reg        <= '0;
         sel_reg         <= '0;
         grant_reg       <= '0;
         last_grant_reg  <= IDX_W'(NUM_REQ - 1);
         timeout_reg     <= 1'b0;
         cfg_pending_reg <= 1'b1;
         cfg_value_reg   <= DIVIDER_INIT;
         wd_reg          <= '0;
      end else begin
         // A new request wins over the clear so a pulse during the start is not lost.
         if (cfg_div_valid_i) begin
            cfg_pending_reg <= 1'b1;
            cfg_value_reg   <= cfg_div_i;
         end else if (start_cfg) begin
            cfg_pending_reg <= 1'b0;
         end

         if (start_cfg) begin
            cyc_reg   <= 1'b1;
            we_reg    <= 1'b1;
            addr_reg  <= WB_ADDR_WIDTH'(UART_BASE);
            data_reg  <= WB_DATA_WIDTH'(cfg_value_reg);
            sel_reg   <= '1;
            grant_reg <= '0;
         end else if (start_byte) begin
            cyc_reg        <= 1'b1;
            we_reg         <= 1'b1;
            addr_reg       <= WB_ADDR_WIDTH'(UART_BASE + 32'd4);
            data_reg       <= WB_DATA_WIDTH'(head_byte[arb_idx]);
            sel_reg        <= SEL_W'(1);
            grant_reg      <= arb_onehot;
            last_grant_reg <= arb_idx;
         end else if (xfer_end) begin
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            grant_reg <= '0;
         end

         if (wd_abort) timeout_reg <= 1'b1;

         if (start_cfg || start_byte)                 wd_reg <= '0;
         else if (state_reg == ST_XFER && wd_reg != '1) wd_reg <= wd_reg + 1'b1;
      end
   end

   assign wbm_cyc_o  = cyc_reg;
   assign wbm_stb_o  = cyc_reg;
   assign wbm_we_o   = we_reg;
   assign wbm_addr_o = addr_reg;
   assign wbm_data_o = data_reg;
   assign wbm_sel_o  = sel_reg;
   assign grant_o    = grant_reg;
   assign timeout_o  = timeout_reg;
   assign busy_o     = (state_reg != ST_IDLE) || (|fifo_nonempty) || cfg_pending_reg;

endmodule

// File: tb/tb_wb_uart_tx_sched.sv
// Bench for wb_uart_tx_sched: directed vector table, hand-written corner sequences,
// and a randomized phase checked against a queue-based model of the arbitration rules.
module tb_wb_uart_tx_sched;

   localparam int TW     = 6;
   localparam int TO_CYC = (1 << TW) - 1;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [1:0]  req_valid_i = '0;
   logic [15:0] req_data_i = '0;
   logic [1:0]  req_ready_o;
   logic        cfg_div_valid_i = 1'b0;
   logic [31:0] cfg_div_i = '0;
   logic [31:0] wbm_addr_o, wbm_data_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
   logic        wbm_ack_i = 1'b0;
   logic [31:0] wbm_rdata = '0;
   logic [1:0]  grant_o;
   logic        busy_o, timeout_o;

   wb_uart_tx_sched #(
      .NUM_REQ(2), .FIFO_DEPTH_LOG2(2), .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32),
      .UART_BASE(32'h0), .DIVIDER_INIT(32'd1), .TIMEOUT_W(TW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .cfg_div_valid_i(cfg_div_valid_i), .cfg_div_i(cfg_div_i),
      .wbm_addr_o(wbm_addr_o), .wbm_data_o(wbm_data_o), .wbm_sel_o(wbm_sel_o),
      .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
      .wbm_ack_i(wbm_ack_i), .wbm_data_i(wbm_rdata),
      .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   int fall_cyc = -100;

   typedef struct {
      int          req;
      logic [7:0]  b;
      int          dly;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      logic [1:0]  grant;
   } vec_t;
   vec_t tbl[4];

   // Reference model state for the randomized phase
   logic [7:0] q_byte[2][$];
   int         q_edge[2][$];
   logic [1:0] pend;
   logic [7:0] pend_b[2];
   logic [7:0] exp_b;
   int         m_last, rfall, ack_cnt, delivered, pushed, pick, waited, n;
   logic       found, prev_cyc, ok;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Waits for a cycle, checks its fields, holds it dly clocks, then acks it.
   task automatic bus_xfer(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] g, input int dly,
                           output int w);
      logic stable;
      w = 0;
      while (!wbm_cyc_o && w < 200) begin
         tick();
         w++;
      end
      if (!wbm_cyc_o) begin
         checks++;
         errors++;
         $display("FAIL %s_start: no cycle after %0d clocks, expected one", nm, w);
      end else begin
         chk({nm, "_gap"}, 32'((cyc_cnt - fall_cyc) >= 2), 1);
         chk({nm, "_addr"}, wbm_addr_o, a);
         chk({nm, "_data"}, wbm_data_o, d);
         chk({nm, "_sel"}, 32'(wbm_sel_o), 32'(s));
         chk({nm, "_we_stb"}, {30'b0, wbm_we_o, wbm_stb_o}, 32'h3);
         chk({nm, "_grant"}, 32'(grant_o), 32'(g));
         stable = 1'b1;
         for (int i = 0; i < dly; i++) begin
            tick();
            if (!(wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_addr_o == a &&
                  wbm_data_o == d && wbm_sel_o == s && grant_o == g)) stable = 1'b0;
         end
         chk({nm, "_hold"}, 32'(stable), 1);
         wbm_ack_i = 1'b1;
         tick();
         wbm_ack_i = 1'b0;
         fall_cyc = cyc_cnt;
         chk({nm, "_drop"}, {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
         chk({nm, "_grant_clr"}, 32'(grant_o), 0);
      end
   endtask

   initial begin
      tbl[0] = '{req: 0, b: 8'h41, dly: 50, addr: 32'h4, data: 32'h41, sel: 4'h1, grant: 2'b01};
      tbl[1] = '{req: 1, b: 8'hA5, dly: 3,  addr: 32'h4, data: 32'hA5, sel: 4'h1, grant: 2'b10};
      tbl[2] = '{req: 0, b: 8'h00, dly: 0,  addr: 32'h4, data: 32'h00, sel: 4'h1, grant: 2'b01};
      tbl[3] = '{req: 1, b: 8'hFF, dly: 1,  addr: 32'h4, data: 32'hFF, sel: 4'h1, grant: 2'b10};

      // Reset state
      repeat (3) tick();
      chk("rst_cyc", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
      chk("rst_addr", wbm_addr_o, 0);
      chk("rst_data", wbm_data_o, 0);
      chk("rst_sel", 32'(wbm_sel_o), 0);
      chk("rst_grant", 32'(grant_o), 0);
      chk("rst_timeout", 32'(timeout_o), 0);
      chk("rst_busy", 32'(busy_o), 1);
      chk("rst_ready", 32'(req_ready_o), 0);

      // Initial divider write on the first edge after reset, then quiet bus
      rst_i = 1'b0;
      bus_xfer("div_init", 32'h0, 32'h1, 4'hF, 2'b00, 0, waited);
      chk("div_init_latency", waited, 1);
      chk("busy_gap", 32'(busy_o), 1);
      tick();
      chk("busy_idle", 32'(busy_o), 0);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wbm_cyc_o) ok = 1'b0;
      end
      chk("idle_quiet", 32'(ok), 1);

      // Table: single bytes with varied ack latency
      for (int v = 0; v < 4; v++) begin
         req_valid_i = '0;
         req_valid_i[tbl[v].req] = 1'b1;
         req_data_i[8*tbl[v].req +: 8] = tbl[v].b;
         chk($sformatf("vec%0d_ready", v), 32'(req_ready_o[tbl[v].req]), 1);
         tick();
         req_valid_i = '0;
         chk($sformatf("vec%0d_early", v), 32'(wbm_cyc_o), 0);
         bus_xfer($sformatf("vec%0d", v), tbl[v].addr, tbl[v].data, tbl[v].sel,
                  tbl[v].grant, tbl[v].dly, waited);
         chk($sformatf("vec%0d_latency", v), waited, 1);
         tick();
      end

      // Both requesters push 0x10..0x13 together: strict alternation from requester 0
      for (int b = 0; b < 4; b++) begin
         req_valid_i = 2'b11;
         req_data_i  = {8'(8'h10 + b), 8'(8'h10 + b)};
         tick();
      end
      req_valid_i = '0;
      for (int i = 0; i < 8; i++) begin
         bus_xfer($sformatf("alt%0d", i), 32'h4, 32'(8'h10 + i / 2), 4'h1,
                  (i % 2 == 0) ? 2'b01 : 2'b10, 0, waited);
      end
      tick();

      // Overflow: five pushes into depth 4 while the UART stalls
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("ovf_ready%0d", i), 32'(req_ready_o[0]), 1);
         req_valid_i = 2'b01;
         req_data_i  = {8'h00, 8'(8'h60 + i)};
         tick();
      end
      chk("ovf_full", 32'(req_ready_o[0]), 0);
      req_data_i = {8'h00, 8'h99};
      tick();
      req_valid_i = '0;
      chk("ovf_still_full", 32'(req_ready_o[0]), 0);
      for (int i = 0; i < 5; i++)
         bus_xfer($sformatf("ovf%0d", i), 32'h4, 32'(8'h60 + i), 4'h1, 2'b01, 1, waited);
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wbm_cyc_o) ok = 1'b0;
      end
      chk("ovf_no_extra", 32'(ok), 1);
      chk("ovf_ready_back", 32'(req_ready_o[0]), 1);

      // Divider requests during a byte transfer: only the latest is written, before the next byte
      req_valid_i = 2'b10;
      req_data_i  = {8'h5A, 8'h00};
      tick();
      req_valid_i = '0;
      tick();
      chk("cfg_byte_started", 32'(wbm_cyc_o), 1);
      cfg_div_valid_i = 1'b1;
      cfg_div_i       = 32'h1B;
      req_valid_i     = 2'b01;
      req_data_i      = {8'h00, 8'h5B};
      tick();
      req_valid_i = '0;
      cfg_div_i   = 32'h36;
      tick();
      cfg_div_valid_i = 1'b0;
      bus_xfer("cfg_b0", 32'h4, 32'h5A, 4'h1, 2'b10, 2, waited);
      bus_xfer("cfg_div", 32'h0, 32'h36, 4'hF, 2'b00, 0, waited);
      bus_xfer("cfg_b1", 32'h4, 32'h5B, 4'h1, 2'b01, 0, waited);
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (wbm_cyc_o) ok = 1'b0;
      end
      chk("cfg_single_div", 32'(ok), 1);

      // Watchdog: no ack, abort after 2^TW-1 cycles, next byte proceeds
      req_valid_i = 2'b11;
      req_data_i  = {8'h3C, 8'hC3};
      tick();
      req_valid_i = '0;
      tick();
      chk("to_start", 32'(wbm_cyc_o), 1);
      chk("to_data", wbm_data_o, 32'h3C);
      chk("to_grant", 32'(grant_o), 32'(2'b10));
      chk("to_flag_before", 32'(timeout_o), 0);
      n = 0;
      while (wbm_cyc_o && n < 200) begin
         tick();
         n++;
      end
      fall_cyc = cyc_cnt;
      chk("to_cycles", n, TO_CYC);
      chk("to_flag", 32'(timeout_o), 1);
      chk("to_grant_clr", 32'(grant_o), 0);
      bus_xfer("to_next", 32'h4, 32'hC3, 4'h1, 2'b01, 3, waited);
      chk("to_sticky", 32'(timeout_o), 1);
      repeat (3) tick();

      // Randomized traffic against the queue model
      m_last = 0;
      rfall = -100;
      ack_cnt = 0;
      delivered = 0;
      pushed = 0;
      pend = '0;
      prev_cyc = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         for (int r = 0; r < 2; r++) begin
            if (pend[r]) begin
               q_byte[r].push_back(pend_b[r]);
               q_edge[r].push_back(cyc_cnt);
               pushed++;
            end
         end
         if (wbm_cyc_o && !prev_cyc) begin
            found = 1'b0;
            pick = 0;
            for (int k = 1; k <= 2; k++) begin
               int r;
               r = (m_last + k) % 2;
               if (!found && q_byte[r].size() > 0 && q_edge[r][0] < cyc_cnt) begin
                  found = 1'b1;
                  pick = r;
               end
            end
            if (!found) begin
               checks++;
               errors++;
               $display("FAIL rand_spurious: cycle at clock %0d with data 0x%0h, expected none",
                        cyc_cnt, wbm_data_o);
            end else begin
               exp_b = q_byte[pick].pop_front();
               void'(q_edge[pick].pop_front());
               chk("rand_addr", wbm_addr_o, 32'h4);
               chk("rand_data", wbm_data_o, {24'b0, exp_b});
               chk("rand_grant", 32'(grant_o), 32'(1 << pick));
               chk("rand_gap", 32'((cyc_cnt - rfall) >= 2), 1);
               m_last = pick;
               delivered++;
            end
            ack_cnt = $urandom_range(0, 6);
         end
         if (!wbm_cyc_o && prev_cyc) rfall = cyc_cnt;
         wbm_ack_i = 1'b0;
         if (wbm_cyc_o) begin
            if (ack_cnt == 0) wbm_ack_i = 1'b1;
            else ack_cnt--;
         end
         for (int r = 0; r < 2; r++) begin
            logic v;
            chk("rand_ready", 32'(req_ready_o[r]), 32'(q_byte[r].size() < 4));
            v = (c < 800) && ($urandom_range(0, 2) == 0);
            pend_b[r] = 8'($urandom);
            req_valid_i[r] = v;
            req_data_i[8*r +: 8] = pend_b[r];
            pend[r] = v && (q_byte[r].size() < 4);
         end
         prev_cyc = wbm_cyc_o;
         tick();
      end
      wbm_ack_i = 1'b0;
      req_valid_i = '0;
      chk("rand_drain", q_byte[0].size() + q_byte[1].size(), 0);
      chk("rand_count", delivered, pushed);
      fall_cyc = cyc_cnt;
      repeat (3) tick();

      // Reset in the middle of a transfer: bus drops, FIFOs flush, divider rewritten
      req_valid_i = 2'b01;
      req_data_i  = {8'h00, 8'hEE};
      tick();
      req_valid_i = 2'b10;
      req_data_i  = {8'h77, 8'h00};
      tick();
      req_valid_i = '0;
      chk("mid_started", 32'(wbm_cyc_o), 1);
      rst_i = 1'b1;
      tick();
      chk("mid_drop", {30'b0, wbm_cyc_o, wbm_stb_o}, 0);
      chk("mid_grant", 32'(grant_o), 0);
      chk("mid_timeout_clr", 32'(timeout_o), 0);
      chk("mid_ready", 32'(req_ready_o), 0);
      rst_i = 1'b0;
      bus_xfer("mid_div", 32'h0, 32'h1, 4'hF, 2'b00, 1, waited);
      chk("mid_div_latency", waited, 1);
      tick();
      chk("mid_busy", 32'(busy_o), 0);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wbm_cyc_o) ok = 1'b0;
      end
      chk("mid_flushed", 32'(ok), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench still running at %0t, expected to have finished", $time);
      $fatal(1);
   end

endmodule
